// File: rtl/inst_prefetch_unit.sv
// -----------------------------------------------------------------------------
// inst_prefetch_unit
//
// Instruction fetch stage. It owns the fetch PC, issues word-indexed reads to
// instruction memory over a req/ack handshake with any latency, buffers the
// returned words with their PCs in a small FIFO and hands them to decode over
// a valid/ready interface. A redirect flushes the buffer and restarts fetch at
// the new PC. A request that is in flight when a redirect arrives stays on
// the bus until it is acked, and its data is then dropped.
//
// Parameters
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//   RESET_PC  fetch PC loaded on reset (word index)
//
// Ports
//   clk_i             clock, all state updates on posedge
//   rst_ni            synchronous active-low reset
//   imem_req_o        instruction read request
//   imem_addr_o       word address, stable while imem_req_o is high
//   imem_ack_i        request complete, imem_rdata_i valid this cycle
//   imem_rdata_i      instruction word
//   redirect_valid_i  load a new fetch PC and flush the buffer
//   redirect_pc_i     new fetch PC (word index)
//   if_valid_o        head entry available
//   if_ready_i        decode accepts the head entry
//   if_instr_o        head instruction
//   if_pc_o           PC of the head instruction
//   perf_stall_cnt_o  decode-starved cycle count
//
// Optional feature
//   FETCH_PERF_CNT_EN  when defined, perf_stall_cnt_o counts cycles with
//                      if_ready_i=1 and if_valid_o=0 (saturating, kept
//                      across redirects). When undefined it is tied to 0.
// -----------------------------------------------------------------------------
module inst_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] perf_stall_cnt_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic          push;
  logic          pop;
  logic          flush;
  logic [CW:0]   credit;
  logic [CW:0]   count_plus1;
  logic          issue_ok;

  assign if_valid_o  = (count_q != '0);
  assign if_instr_o  = instr_mem_q[head_q];
  assign if_pc_o     = pc_mem_q[head_q];
  assign imem_req_o  = (state_q != S_IDLE);
  assign imem_addr_o = addr_q;

  // Credit check on registered values only: an outstanding request already
  // owns a slot, and a pop in the same cycle is deliberately not counted.
  assign credit      = {1'b0, count_q} + {{CW{1'b0}}, (state_q == S_WAIT)};
  assign count_plus1 = {1'b0, count_q} + {{CW{1'b0}}, 1'b1};
  assign issue_ok    = (credit < DEPTH_C);

  // Redirect outranks both push and pop.
  assign pop = if_valid_o && if_ready_i && !redirect_valid_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid_i) begin
      flush      = 1'b1;
      fetch_pc_d = redirect_pc_i;
      // A live request cannot be withdrawn; wait out its ack in DISCARD.
      if (state_q == S_IDLE) begin
        state_d = S_IDLE;
      end else begin
        state_d = imem_ack_i ? S_IDLE : S_DISCARD;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (issue_ok) begin
            state_d = S_WAIT;
            addr_d  = fetch_pc_q;
          end
        end
        S_WAIT: begin
          if (imem_ack_i) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd1;
            // Chain straight into the next request while a slot remains.
            if (count_plus1 < DEPTH_C) begin
              addr_d = fetch_pc_q + 32'd1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (imem_ack_i) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      if (push) begin
        tail_d = tail_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= 32'h0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Storage is cleared on reset so the head outputs read as zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= 32'h0;
        pc_mem_q[i]    <= 32'h0;
      end
    end else if (push) begin
      instr_mem_q[tail_q] <= imem_rdata_i;
      pc_mem_q[tail_q]    <= fetch_pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_q <= 32'h0;
    end else if (if_ready_i && !if_valid_o && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = perf_q;
`else
  assign perf_stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_prefetch_unit
//
// Directed bench for inst_prefetch_unit (DEPTH=4, RESET_PC=0). A small memory
// model answers requests after a programmable number of wait cycles, or can be
// driven by hand to place acks exactly. Inputs change and outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_inst_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] perf_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model controls
  logic mem_auto;
  logic man_ack;
  int   mem_lat;
  int   wait_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  assign imem_ack   = mem_auto ? (imem_req && (wait_cnt == mem_lat)) : man_ack;
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (!mem_auto || !imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  inst_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .if_valid_o(if_valid), .if_ready_i(if_ready),
    .if_instr_o(if_instr), .if_pc_o(if_pc),
    .perf_stall_cnt_o(perf_stall_cnt)
  );

  // Holds reset for two edges and returns at the falling edge where it is released.
  task automatic do_reset(input logic rdy, input int lat);
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_auto = 1'b1; man_ack = 1'b0; mem_lat = lat; if_ready = rdy;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_auto = 1'b1; man_ack = 1'b0; mem_lat = 0; if_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", if_valid); end
    n_cmp++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0", if_instr); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    n_cmp++; if (perf_stall_cnt !== 32'h0) begin n_err++; $display("FAIL rst_perf: got %0d want 0", perf_stall_cnt); end
  endtask

  task automatic test_stream();
    do_reset(1'b1, 0);
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stream_first_req: got %0b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL stream_first_addr: got %h want 0", imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL stream_early_valid: got %0b want 0", if_valid); end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      $display("stream: valid=%0b pc=%h instr=%h", if_valid, if_pc, if_instr);
      n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, if_valid); end
      n_cmp++; if (if_pc !== 32'(i)) begin n_err++; $display("FAIL stream_pc[%0d]: got %h want %h", i, if_pc, 32'(i)); end
      n_cmp++; if (if_instr !== mem_word(32'(i))) begin n_err++; $display("FAIL stream_instr[%0d]: got %h want %h", i, if_instr, mem_word(32'(i))); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int acks = 0;
    int npop = 0;
    logic seen_req = 1'b0;
    logic [31:0] first_addr = 32'hFFFF_FFFF;
    do_reset(1'b0, 0);
    for (int i = 0; i < 12; i++) begin
      if (imem_req && imem_ack) acks++;
      @(negedge clk);
    end
    n_cmp++; if (acks !== 4) begin n_err++; $display("FAIL bp_acks: got %0d want 4", acks); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req_idle: got %0b want 0", imem_req); end
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %0b want 1", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL bp_head_pc: got %h want 0", if_pc); end
    if_ready = 1'b1;
    for (int i = 0; i < 20 && npop < 6; i++) begin
      if (imem_req && !seen_req) begin seen_req = 1'b1; first_addr = imem_addr; end
      if (if_valid) begin
        $display("drain: pc=%h instr=%h", if_pc, if_instr);
        n_cmp++; if (if_pc !== 32'(npop)) begin n_err++; $display("FAIL bp_drain_pc[%0d]: got %h want %h", npop, if_pc, 32'(npop)); end
        n_cmp++; if (if_instr !== mem_word(32'(npop))) begin n_err++; $display("FAIL bp_drain_instr[%0d]: got %h want %h", npop, if_instr, mem_word(32'(npop))); end
        npop++;
      end
      @(negedge clk);
    end
    n_cmp++; if (npop !== 6) begin n_err++; $display("FAIL bp_pop_count: got %0d want 6", npop); end
    n_cmp++; if (first_addr !== 32'h4) begin n_err++; $display("FAIL bp_resume_addr: got %h want 4", first_addr); end
  endtask

  task automatic test_latency();
    int npop = 0;
    int last_pop = 0;
    int stalls = 0;
    logic prev_req = 1'b0;
    logic prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] exp_perf;
    do_reset(1'b1, 3);
    for (int i = 0; i < 20; i++) begin
      if (if_ready && !if_valid) stalls++;
      if (imem_req && prev_req && !prev_ack) begin
        n_cmp++; if (imem_addr !== prev_addr) begin n_err++; $display("FAIL lat_addr_hold[%0d]: got %h want %h", i, imem_addr, prev_addr); end
      end
      if (if_valid) begin
        $display("latency: cycle=%0d pc=%h instr=%h", i, if_pc, if_instr);
        n_cmp++; if (if_pc !== 32'(npop)) begin n_err++; $display("FAIL lat_pc[%0d]: got %h want %h", npop, if_pc, 32'(npop)); end
        if (npop > 0) begin
          n_cmp++; if (i - last_pop !== 4) begin n_err++; $display("FAIL lat_gap[%0d]: got %0d want 4", npop, i - last_pop); end
        end
        last_pop = i;
        npop++;
      end
      prev_req = imem_req; prev_ack = imem_req && imem_ack; prev_addr = imem_addr;
      @(negedge clk);
    end
    n_cmp++; if (npop !== 4) begin n_err++; $display("FAIL lat_pop_count: got %0d want 4", npop); end
`ifdef FETCH_PERF_CNT_EN
    exp_perf = 32'(stalls);
`else
    exp_perf = 32'h0;
`endif
    n_cmp++; if (perf_stall_cnt !== exp_perf) begin n_err++; $display("FAIL perf_cnt: got %0d want %0d", perf_stall_cnt, exp_perf); end
  endtask

  task automatic test_redirect();
    logic found = 1'b0;
    do_reset(1'b1, 0);
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && imem_addr == 32'h5) found = 1'b1;
      else @(negedge clk);
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL redir_setup: got %0b want 1", found); end
    mem_auto = 1'b0; man_ack = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %0b want 0", if_valid); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL redir_req_held: got %0b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h5) begin n_err++; $display("FAIL redir_addr_held: got %h want 5", imem_addr); end
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_idle_req: got %0b want 0", imem_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL redir_discard: got %0b want 0", if_valid); end
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL redir_new_req: got %0b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL redir_new_addr: got %h want 40", imem_addr); end
    mem_auto = 1'b1;
    @(negedge clk);
    $display("redirect: valid=%0b pc=%h instr=%h", if_valid, if_pc, if_instr);
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL redir_valid: got %0b want 1", if_valid); end
    n_cmp++; if (if_pc !== 32'h40) begin n_err++; $display("FAIL redir_pc: got %h want 40", if_pc); end
    n_cmp++; if (if_instr !== mem_word(32'h40)) begin n_err++; $display("FAIL redir_instr: got %h want %h", if_instr, mem_word(32'h40)); end
    // Redirect on the same edge as the ack.
    mem_auto = 1'b0; man_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0; man_ack = 1'b0;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL coinc_req: got %0b want 0", imem_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL coinc_valid: got %0b want 0", if_valid); end
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL coinc_new_req: got %0b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h80) begin n_err++; $display("FAIL coinc_new_addr: got %h want 80", imem_addr); end
    mem_auto = 1'b1;
    @(negedge clk);
    $display("coincident: valid=%0b pc=%h instr=%h", if_valid, if_pc, if_instr);
    n_cmp++; if (if_pc !== 32'h80 || if_valid !== 1'b1) begin n_err++; $display("FAIL coinc_pc: got %h/%0b want 80/1", if_pc, if_valid); end
    @(negedge clk);
    n_cmp++; if (if_pc !== 32'h81) begin n_err++; $display("FAIL coinc_next_pc: got %h want 81", if_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0, 0);
    repeat (3) @(negedge clk);
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_valid: got %0b want 1", if_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h2) begin n_err++; $display("FAIL rmid_pre_req: got %0b/%h want 1/2", imem_req, imem_addr); end
    mem_auto = 1'b0; man_ack = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %0b want 0", if_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_req: got %0b want 0", imem_req); end
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL rmid_restart: got %0b/%h want 1/0", imem_req, imem_addr); end
    mem_auto = 1'b1;
    @(negedge clk);
    $display("reset_mid: valid=%0b pc=%h instr=%h", if_valid, if_pc, if_instr);
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_err++; $display("FAIL rmid_first: got %0b/%h want 1/0", if_valid, if_pc); end
    n_cmp++; if (if_instr !== mem_word(32'h0)) begin n_err++; $display("FAIL rmid_instr: got %h want %h", if_instr, mem_word(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_latency();
    test_redirect();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
